one_hot_in_bcd_out_demux_reg: RTL
=================================

# one_hot_in_bcd_out_demux_reg

Registered write-side counterpart to the router's binary-select/one-hot-output field mux. Accepts a one-hot value (e.g. an output-port grant), encodes it to binary and writes it into the field of a packed per-VC vector addressed by a binary select. The stored packed vector and per-field valid bits are then read back through the mux path. It sits in the VC-based mesh router between the route/switch allocator (one-hot producer) and the per-VC state that holds binary port numbers.

## Interface
- IN_ONE_HOT_WIDTH, 4: width of one incoming one-hot value.
- OUT_BCD_WIDTH, log2(IN_ONE_HOT_WIDTH) = 2: width of one stored binary field.
- SEL_BCD_WIDTH, 2: width of the binary field select.
- SEL_WIDTH, 2**SEL_BCD_WIDTH = 4: number of fields.
- OUT_WIDTH, SEL_WIDTH*OUT_BCD_WIDTH = 8: width of the packed output vector.
- clk  input  1  the single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- wr_en  input  1  write one_hot_in, encoded, into field sel.
- sel  input  SEL_BCD_WIDTH  binary field index for the write.
- one_hot_in  input  IN_ONE_HOT_WIDTH  value to encode and store.
- clr_en  input  1  invalidate field clr_sel.
- clr_sel  input  SEL_BCD_WIDTH  binary field index for the clear.
- demux_out  output  OUT_WIDTH  packed stored fields; field i occupies bits [i*OUT_BCD_WIDTH +: OUT_BCD_WIDTH].
- field_valid  output  SEL_WIDTH  bit i set while field i holds a written value.
- onehot_err  output  1  sticky error flag; present only with ONE_HOT_CHECK_EN.

## Operation
- Encode: the binary index of the set bit of one_hot_in. If several bits are set, the lowest index wins. All-zero encodes to 0.
- Write: wr_en=1 loads the encoded value into field sel and sets field_valid[sel]. Other fields hold.
- Clear: clr_en=1 clears field_valid[clr_sel]. The field data holds its last value and is not zeroed.
- Write and clear to the same field in the same cycle: the write wins, so field_valid stays set and the new data is stored.
- Write and clear to different fields in the same cycle: both take effect.
- Back-to-back writes to the same field: the last write wins, with no stall and no backpressure.
- Reset: demux_out = 0, field_valid = 0, onehot_err = 0. Reset overrides wr_en and clr_en in the same cycle.
- Reset mid-stream: state returns to the reset values on the next edge. Writes in the reset cycle are dropped.

## Timing
- Write latency is 1 cycle: wr_en sampled at edge N, and demux_out and field_valid reflect it after edge N.
- Clear latency is 1 cycle.
- demux_out and field_valid are direct register outputs, with no combinational path from the inputs.
- onehot_err sets 1 cycle after the offending write.
- Sustained throughput is one write plus one clear per cycle.

## Configuration
- Macro: ONE_HOT_CHECK_EN.
- Defined:
  - A write with one_hot_in not exactly one-hot (zero bits or more than one bit set) sets onehot_err at the next edge.
  - onehot_err remains set until reset.
  - The write is still performed using the lowest-index encoding.
- Undefined:
  - No check logic.
  - The onehot_err port is absent.
  - Encoding behaviour is identical to the defined case.

## Structure
- Shared package/header: the log2 constant function and the field-slice width constants used by both this block and the read-side mux.
- One sub-module: one_hot_to_bcd, a purely combinational lowest-index priority encoder. It is the inverse of bcd_to_one_hot.
- The register array, valid bits and error logic live in the top module.

## Test plan
- Basic write:
  - Stimulus: after reset, wr_en=1, sel=2, one_hot_in=4'b1000.
  - Required: next cycle demux_out=8'b0011_0000, field_valid=4'b0100.
- Fill all fields:
  - Stimulus: write sel=0..3 with one_hot_in 4'b0001, 4'b0010, 4'b0100, 4'b1000 on consecutive cycles.
  - Required: demux_out=8'b11_10_01_00, field_valid=4'b1111.
- Clear:
  - Stimulus: clr_en=1, clr_sel=1.
  - Required: field_valid=4'b1101, demux_out unchanged.
  - Stimulus: same-cycle write and clear to field 3 with one_hot_in 4'b0010.
  - Required: field_valid[3]=1 and field 3 = 2'b01.
- Illegal input (macro defined):
  - Stimulus: wr_en=1, sel=0, one_hot_in=4'b0110.
  - Required: field 0 = 2'b01, onehot_err=1 next cycle and still 1 ten cycles later.
  - Stimulus: one_hot_in=4'b0000.
  - Required: field stores 0, onehot_err=1.
- Reset mid-operation:
  - Stimulus: assert reset in the same cycle as wr_en=1, sel=1.
  - Required: demux_out=0, field_valid=0, onehot_err=0 on the next cycle, and the write is discarded.

Source files
------------

// File: rtl/one_hot_in_bcd_out_demux_reg_pkg.sv
// Shared constants and helpers for the one-hot-in / BCD-out field register.
// Holds field-slice widths used by this block and the read-side mux.
package one_hot_in_bcd_out_demux_reg_pkg;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int IN_ONE_HOT_WIDTH = 4;
  localparam int OUT_BCD_WIDTH    = log2(IN_ONE_HOT_WIDTH);
  localparam int SEL_BCD_WIDTH    = 2;
  localparam int SEL_WIDTH        = 1 << SEL_BCD_WIDTH;
  localparam int OUT_WIDTH        = SEL_WIDTH * OUT_BCD_WIDTH;

endpackage

// File: rtl/one_hot_in_bcd_out_demux_reg_if.sv
// Write/clear command bus and stored-field readback for the field register.
// master drives commands, slave (the register) returns fields; onehot_err
// exists only when ONE_HOT_CHECK_EN is defined.
interface one_hot_in_bcd_out_demux_reg_if;
  import one_hot_in_bcd_out_demux_reg_pkg::*;

  logic                        wr_en;
  logic [SEL_BCD_WIDTH-1:0]    sel;
  logic [IN_ONE_HOT_WIDTH-1:0] one_hot_in;
  logic                        clr_en;
  logic [SEL_BCD_WIDTH-1:0]    clr_sel;
  logic [OUT_WIDTH-1:0]        demux_out;
  logic [SEL_WIDTH-1:0]        field_valid;
`ifdef ONE_HOT_CHECK_EN
  logic                        onehot_err;
`endif

  modport master (
    output wr_en, sel, one_hot_in, clr_en, clr_sel,
`ifdef ONE_HOT_CHECK_EN
    input  onehot_err,
`endif
    input  demux_out, field_valid
  );

  modport slave (
    input  wr_en, sel, one_hot_in, clr_en, clr_sel,
`ifdef ONE_HOT_CHECK_EN
    output onehot_err,
`endif
    output demux_out, field_valid
  );

endinterface

// File: rtl/one_hot_in_bcd_out_demux_reg_one_hot_to_bcd.sv
// Combinational lowest-index priority encoder (inverse of bcd_to_one_hot).
// Ports: onehot_i (one-hot value), bcd_o (index of lowest set bit, 0 if none).
module one_hot_to_bcd
  import one_hot_in_bcd_out_demux_reg_pkg::*;
#(
  parameter int W  = IN_ONE_HOT_WIDTH,
  parameter int BW = log2(W)
) (
  input  logic [W-1:0]  onehot_i,
  output logic [BW-1:0] bcd_o
);

  // Scan from the top down so the lowest set bit is assigned last.
  always_comb begin
    bcd_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (onehot_i[i]) bcd_o = BW'(i);
    end
  end

endmodule

// File: rtl/one_hot_in_bcd_out_demux_reg.sv
// Registered one-hot -> binary field writer with per-field valid bits.
// Ports: clk, reset (sync, active-high), bus (slave modport). Define
// ONE_HOT_CHECK_EN to add the sticky onehot_err flag.
module one_hot_in_bcd_out_demux_reg
  import one_hot_in_bcd_out_demux_reg_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  one_hot_in_bcd_out_demux_reg_if.slave      bus
);

  logic [OUT_BCD_WIDTH-1:0]                enc;
  logic [SEL_WIDTH-1:0][OUT_BCD_WIDTH-1:0] data_q, data_d;
  logic [SEL_WIDTH-1:0]                    valid_q, valid_d;

  one_hot_to_bcd #(
    .W  (IN_ONE_HOT_WIDTH),
    .BW (OUT_BCD_WIDTH)
  ) u_enc (
    .onehot_i (bus.one_hot_in),
    .bcd_o    (enc)
  );

  // Clear is applied first so a same-field write overrides it.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (bus.clr_en) valid_d[bus.clr_sel] = 1'b0;
    if (bus.wr_en) begin
      data_d[bus.sel]  = enc;
      valid_d[bus.sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.demux_out   = data_q;
  assign bus.field_valid = valid_q;

`ifdef ONE_HOT_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (bus.wr_en && !$onehot(bus.one_hot_in)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.onehot_err = err_q;
`endif

endmodule
